// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, keeps one imem read in flight and buffers {pc, instr} for decode.
// Head valid the cycle after rvalid; requests stop while the buffer is full. `FETCH_ALIGN_CHECK_EN halts on misaligned redirect.
module fetch_unit #(
   parameter int unsigned          AddrWidth   = 32,
   parameter int unsigned          InstrWidth  = 32,
   parameter logic [AddrWidth-1:0] ResetVector = '0,
   parameter int unsigned          BufDepth    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  imemReq,
   output logic [AddrWidth-1:0]  imemAddr,
   input  logic                  imemGnt,
   input  logic                  imemRvalid,
   input  logic [InstrWidth-1:0] imemRdata,
   output logic                  instrValid,
   output logic [InstrWidth-1:0] instr,
   output logic [AddrWidth-1:0]  pcReadData,
   input  logic                  instrReady,
   input  logic                  pcWriteEnable,
   input  logic [AddrWidth-1:0]  pcWriteData,
   output logic                  fetchFault
);

   localparam int unsigned PtrW = (BufDepth > 1) ? $clog2(BufDepth) : 1;
   localparam int unsigned CntW = $clog2(BufDepth + 1);
   localparam logic [InstrWidth-1:0] Nop = InstrWidth'(32'h0000_0013);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_HALT} state_e;

   state_e               state_q, state_d;
   logic [AddrWidth-1:0] fetch_pc_q, fetch_pc_d;
   logic [AddrWidth-1:0] req_pc_q, req_pc_d;
   logic [PtrW-1:0]      head_q, head_d;
   logic [PtrW-1:0]      tail_q, tail_d;
   logic [CntW-1:0]      count_q, count_d;
   logic                 started_q, started_d;

   logic [AddrWidth-1:0]  buf_pc_q    [BufDepth];
   logic [InstrWidth-1:0] buf_instr_q [BufDepth];

   logic                 grant, push, pop, redirect, halt_redirect;
   logic                 buf_full, buf_empty;
   logic [AddrWidth-1:0] redirect_pc;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == PtrW'(BufDepth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign buf_full    = (count_q == CntW'(BufDepth));
   assign buf_empty   = (count_q == '0);
   assign redirect    = pcWriteEnable && (state_q != S_HALT);
   assign redirect_pc = {pcWriteData[AddrWidth-1:2], 2'b00};
   assign grant       = imemReq && imemGnt;
   // A redirect overrides everything else in its cycle: no push, no pop.
   assign push        = (state_q == S_WAIT) && imemRvalid && !redirect;
   assign pop         = !buf_empty && instrReady && !redirect;

`ifdef FETCH_ALIGN_CHECK_EN
   logic fault_q, fault_d;

   assign halt_redirect = redirect && (pcWriteData[1:0] != 2'b00);
   assign fault_d       = fault_q || halt_redirect;
   assign fetchFault    = fault_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end
`else
   logic unused_addr_lsbs;

   assign unused_addr_lsbs = ^pcWriteData[1:0];
   assign halt_redirect    = 1'b0;
   assign fetchFault       = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_REQ;
         fetch_pc_q <= ResetVector;
         req_pc_q   <= ResetVector;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         started_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         started_q  <= started_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_pc_q[tail_q]    <= req_pc_q;
         buf_instr_q[tail_q] <= imemRdata;
      end
   end

   // A request granted in the redirect cycle is still owed a response, hence DRAIN.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_REQ: begin
            if (redirect) begin
               state_d = grant ? S_DRAIN : S_REQ;
            end else if (grant) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               state_d = imemRvalid ? S_REQ : S_DRAIN;
            end else if (imemRvalid) begin
               state_d = S_REQ;
            end
         end
         S_DRAIN: begin
            if (imemRvalid) begin
               state_d = S_REQ;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
      if (halt_redirect) begin
         state_d = S_HALT;
      end
   end

   always_comb begin
      started_d  = 1'b1;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end else begin
         if (grant) begin
            fetch_pc_d = fetch_pc_q + AddrWidth'(4);
            req_pc_d   = fetch_pc_q;
         end
         if (push) begin
            tail_d = next_ptr(tail_q);
         end
         if (pop) begin
            head_d = next_ptr(head_q);
         end
         count_d = count_q + CntW'(push) - CntW'(pop);
      end
   end

   // started_q keeps imemReq low during reset and for the first cycle after it.
   always_comb begin
      imemReq    = started_q && (state_q == S_REQ) && !buf_full;
      imemAddr   = fetch_pc_q;
      instrValid = !buf_empty;
      instr      = Nop;
      pcReadData = '0;
      if (!buf_empty) begin
         instr      = buf_instr_q[head_q];
         pcReadData = buf_pc_q[head_q];
      end
   end

endmodule
